// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter at the commit boundary. It decides whether the committing
// instruction traps, pulses one event flag to CP0, and holds a flush/redirect until fetch
// accepts it.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                mem_valid,
  input  logic                mem_syscall,
  input  logic                mem_break,
  input  logic                mem_eret,
  input  logic                mem_delayslot,
  input  logic [31:0]         mem_pc,
  input  logic                stall_i,
  input  logic [31:0]         status_i,
  input  logic [31:0]         cause_i,
  input  logic [31:0]         epc_i,
  input  logic                redirect_ready,
  output logic                syscall_flag,
  output logic                break_flag,
  output logic                eret_flag,
  output logic                int_flag,
  output logic                delayslot_flag,
  output logic [31:0]         current_pc_addr,
  output logic [HW_INT_W-1:0] hw_int_pending,
  output logic                flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HOLD} state_t;

  state_t              r_state, w_next;
  logic [HW_INT_W-1:0] r_sync1, r_sync2;
  logic                r_sys, r_brk, r_eret, r_int, r_ds;
  logic [31:0]         r_pc, r_rpc;
  logic                w_int_req, w_take;
  logic                w_win_int, w_win_brk, w_win_sys, w_win_eret;
  logic                w_unused;

  // Pending lines and the two software bits share the IM mask in status[15:8].
  assign w_int_req = status_i[0] & ~status_i[1] &
                     (|({r_sync2, cause_i[9:8]} & status_i[HW_INT_W+9:8]));

  assign w_take = (r_state == S_IDLE) & mem_valid & ~stall_i &
                  (w_int_req | mem_syscall | mem_break | mem_eret);

  assign w_win_int  = w_take & w_int_req;
  assign w_win_brk  = w_take & ~w_int_req & mem_break;
  assign w_win_sys  = w_take & ~w_int_req & ~mem_break & mem_syscall;
  assign w_win_eret = w_take & ~w_int_req & ~mem_break & ~mem_syscall & mem_eret;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_FLUSH;
      S_FLUSH: w_next = redirect_ready ? S_IDLE : S_HOLD;
      S_HOLD:  if (redirect_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sys   <= 1'b0;
      r_brk   <= 1'b0;
      r_eret  <= 1'b0;
      r_int   <= 1'b0;
      r_ds    <= 1'b0;
      r_pc    <= '0;
      r_rpc   <= '0;
    end else begin
      r_state <= w_next;
      r_sync1 <= hw_int;
      r_sync2 <= r_sync1;
      // Flags are only ever set on the take edge, so they last exactly the FLUSH cycle.
      r_int   <= w_win_int;
      r_brk   <= w_win_brk;
      r_sys   <= w_win_sys;
      r_eret  <= w_win_eret;
      if (w_take) begin
        r_ds  <= mem_delayslot;
        r_pc  <= mem_pc;
        r_rpc <= w_win_eret ? epc_i : EXC_VECTOR;
      end
    end
  end

  assign syscall_flag    = r_sys;
  assign break_flag      = r_brk;
  assign eret_flag       = r_eret;
  assign int_flag        = r_int;
  assign delayslot_flag  = r_ds;
  assign current_pc_addr = r_pc;
  assign hw_int_pending  = r_sync2;
  assign flush           = (r_state != S_IDLE);
  assign redirect_valid  = (r_state != S_IDLE);
  assign redirect_pc     = r_rpc;

  assign w_unused = ^{status_i[31:HW_INT_W+10], status_i[7:2], cause_i[31:10],
                      cause_i[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a per-cycle behavioural model checked on every negedge,
// plus literal expectations at key points of each scenario.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        mem_valid, mem_syscall, mem_break, mem_eret, mem_delayslot;
  logic [31:0] mem_pc;
  logic        stall_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        redirect_ready;
  logic        syscall_flag, break_flag, eret_flag, int_flag, delayslot_flag;
  logic [31:0] current_pc_addr;
  logic [5:0]  hw_int_pending;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .mem_valid(mem_valid),
    .mem_syscall(mem_syscall), .mem_break(mem_break), .mem_eret(mem_eret),
    .mem_delayslot(mem_delayslot), .mem_pc(mem_pc), .stall_i(stall_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .redirect_ready(redirect_ready), .syscall_flag(syscall_flag),
    .break_flag(break_flag), .eret_flag(eret_flag), .int_flag(int_flag),
    .delayslot_flag(delayslot_flag), .current_pc_addr(current_pc_addr),
    .hw_int_pending(hw_int_pending), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a redirect is either outstanding or not; flags are a one-cycle pulse
  // naming the winning event; interrupt lines reach 'pending' two edges after they change.
  logic [5:0]  m_s1 = '0, m_pend = '0;
  logic        m_busy = 0;
  logic [3:0]  m_flags = '0;          // {int, break, syscall, eret}
  logic        m_ds = 0;
  logic [31:0] m_pc = '0, m_rpc = '0;
  logic        started = 0;

  always @(posedge clk) begin
    logic ireq;
    started = 1;
    if (!rst) begin
      m_s1 = '0; m_pend = '0; m_busy = 0; m_flags = '0;
      m_ds = 0; m_pc = '0; m_rpc = '0;
    end else begin
      ireq = status_i[0] && !status_i[1] &&
             (({m_pend, cause_i[9:8]} & status_i[15:8]) != 8'd0);
      if (m_busy) begin
        m_flags = '0;
        if (redirect_ready) m_busy = 0;
      end else if (mem_valid && !stall_i &&
                   (ireq || mem_syscall || mem_break || mem_eret)) begin
        m_busy = 1;
        if (ireq)             m_flags = 4'b1000;
        else if (mem_break)   m_flags = 4'b0100;
        else if (mem_syscall) m_flags = 4'b0010;
        else                  m_flags = 4'b0001;
        m_ds  = mem_delayslot;
        m_pc  = mem_pc;
        m_rpc = m_flags[0] ? epc_i : VEC;
      end
      m_pend = m_s1;
      m_s1   = hw_int;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_flags", {28'd0, int_flag, break_flag, syscall_flag, eret_flag}, {28'd0, m_flags});
      chk("m_ds", {31'd0, delayslot_flag}, {31'd0, m_ds});
      chk("m_pc", current_pc_addr, m_pc);
      chk("m_pend", {26'd0, hw_int_pending}, {26'd0, m_pend});
      chk("m_flush", {30'd0, flush, redirect_valid}, {30'd0, m_busy, m_busy});
      chk("m_rpc", redirect_pc, m_rpc);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_commit();
    mem_valid = 0; mem_syscall = 0; mem_break = 0; mem_eret = 0; mem_delayslot = 0;
  endtask

  initial begin
    rst = 0; hw_int = '0; clr_commit(); mem_pc = '0; stall_i = 0;
    status_i = '0; cause_i = '0; epc_i = '0; redirect_ready = 1;

    // reset, then syscall
    cyc(2);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_pc", current_pc_addr, 32'd0);
    rst = 1;
    mem_valid = 1; mem_syscall = 1; mem_pc = 32'h80001000;
    cyc(); clr_commit();
    chk("sys_flag", {31'd0, syscall_flag}, 32'd1);
    chk("sys_pc", current_pc_addr, 32'h80001000);
    chk("sys_rpc", redirect_pc, 32'hBFC00380);
    chk("sys_flush", {31'd0, flush}, 32'd1);
    cyc();
    chk("sys_flag_off", {31'd0, syscall_flag}, 32'd0);
    chk("sys_flush_off", {31'd0, flush}, 32'd0);

    // eret under backpressure
    epc_i = 32'h80002004; mem_valid = 1; mem_eret = 1; redirect_ready = 0;
    cyc(); clr_commit();
    chk("eret_flag", {31'd0, eret_flag}, 32'd1);
    chk("eret_rpc", redirect_pc, 32'h80002004);
    cyc();
    chk("eret_flag_off", {31'd0, eret_flag}, 32'd0);
    chk("eret_hold1", {31'd0, redirect_valid}, 32'd1);
    cyc();
    chk("eret_hold2", {31'd0, flush}, 32'd1);
    cyc(); redirect_ready = 1;
    chk("eret_hold3", {31'd0, flush}, 32'd1);
    chk("eret_rpc_hold", redirect_pc, 32'h80002004);
    cyc();
    chk("eret_idle", {30'd0, flush, redirect_valid}, 32'd0);

    // interrupt through the synchroniser
    status_i = 32'h0000FF01; hw_int = 6'd1;
    cyc();
    chk("sync_1cyc", {26'd0, hw_int_pending}, 32'd0);
    cyc();
    chk("sync_2cyc", {26'd0, hw_int_pending}, 32'd1);
    mem_valid = 1; mem_pc = 32'h80000200;
    cyc(); clr_commit();
    chk("int_flag", {31'd0, int_flag}, 32'd1);
    chk("int_rpc", redirect_pc, VEC);
    cyc();
    status_i = 32'h0000FF03; mem_valid = 1;
    cyc();
    chk("int_exl", {31'd0, flush}, 32'd0);
    status_i = 32'h0000FF00;
    cyc();
    chk("int_ie0", {31'd0, flush}, 32'd0);
    clr_commit();

    // interrupt beats break, delay slot
    status_i = 32'h0000FF01;
    mem_valid = 1; mem_break = 1; mem_delayslot = 1; mem_pc = 32'h80000104;
    cyc(); clr_commit();
    chk("ib_int", {31'd0, int_flag}, 32'd1);
    chk("ib_brk", {31'd0, break_flag}, 32'd0);
    chk("ib_ds", {31'd0, delayslot_flag}, 32'd1);
    chk("ib_pc", current_pc_addr, 32'h80000104);
    cyc();
    status_i = '0; hw_int = '0;
    cyc(2);

    // stall gating
    stall_i = 1; mem_valid = 1; mem_syscall = 1; mem_pc = 32'h80000300;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_flush", {31'd0, flush}, 32'd0);
    end
    stall_i = 0;
    cyc(); clr_commit();
    chk("stall_take", {31'd0, syscall_flag}, 32'd1);
    chk("stall_ds", {31'd0, delayslot_flag}, 32'd0);
    cyc();

    // mem_valid gating
    mem_break = 1;
    cyc(2);
    chk("nv_flush", {31'd0, flush}, 32'd0);
    clr_commit();

    // software interrupt via cause[8]
    status_i = 32'h00000101; cause_i = 32'h00000100; mem_valid = 1; mem_pc = 32'h80000400;
    cyc(); clr_commit();
    chk("sw_int", {31'd0, int_flag}, 32'd1);
    cyc();
    status_i = '0; cause_i = '0;

    // reset while holding
    hw_int = 6'h21;
    cyc(2);
    mem_valid = 1; mem_syscall = 1; redirect_ready = 0;
    cyc(); clr_commit();
    cyc();
    chk("hold_flush", {31'd0, flush}, 32'd1);
    rst = 0;
    cyc();
    chk("rh_flush", {30'd0, flush, redirect_valid}, 32'd0);
    chk("rh_pend", {26'd0, hw_int_pending}, 32'd0);
    chk("rh_flags", {28'd0, int_flag, break_flag, syscall_flag, eret_flag}, 32'd0);
    rst = 1; redirect_ready = 1; hw_int = '0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
